// File: rtl/reset_sequencer.sv
// ============================================================================
// reset_sequencer
//
// Generates ordered, per-domain active-low resets from the board reset and a
// PLL lock indication. All domains are held in reset until lock has been
// stable for LOCK_FILT cycles. They are then released one at a time, bit 0
// first, with STAGE_DLY cycles between releases. Lock loss, or a software
// reset request (req/ack handshake), re-asserts every output.
//
// Ports:
//   clk           system clock
//   rstb          asynchronous active-low reset
//   pll_locked    PLL lock, asynchronous to clk (double-flop synchronised here)
//   soft_rst_req  software reset request; a rising edge is the request event
//   soft_rst_ack  one-cycle completion pulse for soft_rst_req
//   rstb_out      sequenced active-low resets, one per domain (registered)
//   rst_done      high while every output is released (state RUN)
//   state         current state: HOLD=0, RELEASE=1, RUN=2, ASSERT=3
//   lock_timeout  sticky flag, set after TIMEOUT_CYC cycles in HOLD
//                 (port present only when RST_SEQ_TIMEOUT_EN is defined)
//
// Optional feature macro: RST_SEQ_TIMEOUT_EN
//
// State table:
//   state   | meaning
//   HOLD    | all outputs low, qualifying lock_s for LOCK_FILT cycles
//   RELEASE | releasing outputs one by one, STAGE_DLY cycles apart
//   RUN     | all outputs released, rst_done high
//   ASSERT  | soft reset: all outputs low for STRETCH cycles, then ack
// ============================================================================
module reset_sequencer #(
    parameter int NUM_OUT     = 3,
    parameter int STAGE_DLY   = 16,
    parameter int LOCK_FILT   = 4,
    parameter int STRETCH     = 8
`ifdef RST_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000
`endif
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               pll_locked,
    input  logic               soft_rst_req,
    output logic               soft_rst_ack,
    output logic [NUM_OUT-1:0] rstb_out,
    output logic               rst_done,
    output logic [1:0]         state
`ifdef RST_SEQ_TIMEOUT_EN
    ,
    output logic               lock_timeout
`endif
);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_ASSERT  = 2'd3
    } state_t;

    localparam int FW = $clog2(LOCK_FILT + 1);
    localparam int SW = $clog2(STAGE_DLY * NUM_OUT + 2);
    localparam int TW = $clog2(STRETCH + 1);

    localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILT);
    localparam logic [TW-1:0] STR_LOAD = TW'(STRETCH - 1);

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic               req_q;
    logic [FW-1:0]      filt_cnt_q, filt_cnt_d;
    logic [SW-1:0]      stage_cnt_q, stage_cnt_d;
    logic [TW-1:0]      str_cnt_q, str_cnt_d;
    logic               ack_q, ack_d;
    logic [NUM_OUT-1:0] rstb_out_q, rstb_out_d;

    logic lock_s;
    logic soft_edge;

    assign lock_s    = sync2_q;
    assign soft_edge = soft_rst_req & ~req_q;

    // Priority in RELEASE/RUN: lock loss, then soft request, then progress.
    // A request that coincides with lock loss is acked straight from HOLD.
    always_comb begin
        state_d     = state_q;
        filt_cnt_d  = '0;
        stage_cnt_d = '0;
        str_cnt_d   = '0;
        ack_d       = 1'b0;
        rstb_out_d  = '0;
        case (state_q)
            ST_HOLD: begin
                ack_d = soft_edge;
                if (filt_cnt_q == FILT_MAX) begin
                    state_d = ST_RELEASE;
                end else if (lock_s) begin
                    filt_cnt_d = filt_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    state_d = ST_HOLD;
                    ack_d   = soft_edge;
                end else if (soft_edge) begin
                    state_d   = ST_ASSERT;
                    str_cnt_d = STR_LOAD;
                end else if (rstb_out_q[NUM_OUT-1]) begin
                    state_d    = ST_RUN;
                    rstb_out_d = '1;
                end else begin
                    stage_cnt_d = stage_cnt_q + 1'b1;
                    for (int i = 0; i < NUM_OUT; i++) begin
                        rstb_out_d[i] = rstb_out_q[i] |
                                        (stage_cnt_d >= SW'(STAGE_DLY * (i + 1)));
                    end
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_HOLD;
                    ack_d   = soft_edge;
                end else if (soft_edge) begin
                    state_d   = ST_ASSERT;
                    str_cnt_d = STR_LOAD;
                end else begin
                    rstb_out_d = '1;
                end
            end
            ST_ASSERT: begin
                // lock_s is deliberately ignored here; HOLD re-qualifies it.
                if (str_cnt_q == '0) begin
                    state_d = ST_HOLD;
                    ack_d   = 1'b1;
                end else begin
                    str_cnt_d = str_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_HOLD;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            req_q       <= 1'b0;
            filt_cnt_q  <= '0;
            stage_cnt_q <= '0;
            str_cnt_q   <= '0;
            ack_q       <= 1'b0;
            rstb_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= pll_locked;
            sync2_q     <= sync1_q;
            req_q       <= soft_rst_req;
            filt_cnt_q  <= filt_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            str_cnt_q   <= str_cnt_d;
            ack_q       <= ack_d;
            rstb_out_q  <= rstb_out_d;
        end
    end

    assign rstb_out     = rstb_out_q;
    assign soft_rst_ack = ack_q;
    assign rst_done     = (state_q == ST_RUN);
    assign state        = state_q;

`ifdef RST_SEQ_TIMEOUT_EN
    localparam int            HW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [HW-1:0] TO_MAX = HW'(TIMEOUT_CYC);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q, timeout_d;

    // Dwell counter saturates so the flag cannot be re-armed by wrap-around.
    always_comb begin
        hold_cnt_d = '0;
        timeout_d  = timeout_q;
        if (state_q == ST_HOLD) begin
            hold_cnt_d = (hold_cnt_q == TO_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
            if (hold_cnt_d == TO_MAX) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign lock_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// tb_reset_sequencer
//
// Bench for reset_sequencer: directed scenarios plus randomized lock/request/
// reset traffic. A behavioural model tracks state as "time since entry" and
// "consecutive qualified lock edges"; outputs are compared every cycle.
// ============================================================================
module tb_reset_sequencer;

    localparam int NUM_OUT   = 3;
    localparam int STAGE_DLY = 16;
    localparam int LOCK_FILT = 4;
    localparam int STRETCH   = 8;
`ifdef RST_SEQ_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 50;
`endif

    logic               clk          = 1'b0;
    logic               rstb         = 1'b0;
    logic               pll_locked   = 1'b0;
    logic               soft_rst_req = 1'b0;
    logic               soft_rst_ack;
    logic [NUM_OUT-1:0] rstb_out;
    logic               rst_done;
    logic [1:0]         state;
`ifdef RST_SEQ_TIMEOUT_EN
    logic               lock_timeout;
`endif

    reset_sequencer #(
        .NUM_OUT     (NUM_OUT),
        .STAGE_DLY   (STAGE_DLY),
        .LOCK_FILT   (LOCK_FILT),
        .STRETCH     (STRETCH)
`ifdef RST_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .rstb_out     (rstb_out),
        .rst_done     (rst_done),
        .state        (state)
`ifdef RST_SEQ_TIMEOUT_EN
        ,
        .lock_timeout (lock_timeout)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;   // edges since rstb was last released

    // ---------------- behavioural model ----------------
    // m_state uses the externally visible state numbering.
    int m_state   = 0;
    int m_entry   = 0;    // edge at which the current state was entered
    int m_hi_run  = 0;    // consecutive lock_s=1 edges seen in HOLD
    bit m_p1 = 1'b0, m_p2 = 1'b0;   // pll_locked samples 1 and 2 edges back
    bit m_req_prev = 1'b0;
    bit m_ack = 1'b0;
    bit m_ls, m_se;
    int m_hold_edges = 0;
    bit m_to = 1'b0;

    function automatic logic [NUM_OUT-1:0] m_outs();
        logic [NUM_OUT-1:0] o;
        o = '0;
        if (m_state == 2) o = '1;
        else if (m_state == 1) begin
            for (int i = 0; i < NUM_OUT; i++)
                o[i] = ((ecnt - m_entry) >= STAGE_DLY * (i + 1));
        end
        return o;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rstb) begin
            m_state = 0; m_entry = 0; m_hi_run = 0;
            m_p1 = 0; m_p2 = 0; m_req_prev = 0; m_ack = 0;
            m_hold_edges = 0; m_to = 0; ecnt = 0;
        end else begin
            ecnt++;
            m_ls = m_p2;
            m_p2 = m_p1;
            m_p1 = pll_locked;
            m_se = soft_rst_req && !m_req_prev;
            m_req_prev = soft_rst_req;
            m_ack = 1'b0;
            if (m_state == 0) begin
                m_hold_edges++;
                if (m_hold_edges >= `ifdef RST_SEQ_TIMEOUT_EN TIMEOUT_CYC `else 1 `endif) m_to = 1'b1;
            end else begin
                m_hold_edges = 0;
            end
            case (m_state)
                0: begin
                    if (m_se) m_ack = 1'b1;
                    if (m_hi_run >= LOCK_FILT) begin
                        m_state = 1; m_entry = ecnt; m_hi_run = 0;
                    end else begin
                        m_hi_run = m_ls ? m_hi_run + 1 : 0;
                    end
                end
                1, 2: begin
                    if (!m_ls) begin
                        m_state = 0; m_hi_run = 0; m_ack = m_se;
                    end else if (m_se) begin
                        m_state = 3; m_entry = ecnt;
                    end else if (m_state == 1 && (ecnt - m_entry) > STAGE_DLY * NUM_OUT) begin
                        m_state = 2;
                    end
                end
                default: begin
                    if ((ecnt - m_entry) >= STRETCH) begin
                        m_state = 0; m_ack = 1'b1; m_hi_run = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NUM_OUT+3:0] act_v, exp_v;
    initial forever begin
        @(negedge clk);
        act_v = {state, rstb_out, rst_done, soft_rst_ack};
        if (!rstb) exp_v = '0;
        else exp_v = {m_state[1:0], m_outs(), (m_state == 2), m_ack};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            if (errors <= 20)
                $display("FAIL cycle_cmp t=%0t edge=%0d {state,rstb_out,done,ack} actual=%b required=%b",
                         $time, ecnt, act_v, exp_v);
        end
`ifdef RST_SEQ_TIMEOUT_EN
        checks++;
        if (lock_timeout !== (rstb ? m_to : 1'b0)) begin
            errors++;
            if (errors <= 20)
                $display("FAIL timeout_cmp t=%0t actual=%b required=%b", $time, lock_timeout, m_to);
        end
`endif
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%0d required=%0d", name, ecnt, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rstb = 1'b0; pll_locked = 1'b0; soft_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rstb = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (rst_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rst_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done actual=%b required=1 within %0d cycles", rst_done, budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Power-up with defaults: lock rises before edge 10.
        do_reset();
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            case (ecnt)
                1:  lit("reset_state", int'(state), 0);
                15: lit("hold_at_15", int'(state), 0);
                16: begin lit("release_at_16", int'(state), 1); lit("out_at_16", int'(rstb_out), 0); end
                31: lit("out_at_31", int'(rstb_out), 0);
                32: lit("out_at_32", int'(rstb_out), 1);
                47: lit("out_at_47", int'(rstb_out), 1);
                48: lit("out_at_48", int'(rstb_out), 3);
                63: lit("out_at_63", int'(rstb_out), 3);
                64: begin lit("out_at_64", int'(rstb_out), 7); lit("done_at_64", int'(rst_done), 0); end
                65: begin lit("done_at_65", int'(rst_done), 1); lit("run_at_65", int'(state), 2); end
                default: ;
            endcase
            if (ecnt == 9) #2 pll_locked = 1'b1;
        end

        // Lock loss in RUN: outputs low within 3 edges, then resequence.
        @(negedge clk); #2 pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        lit("lossrun_out", int'(rstb_out), 0);
        lit("lossrun_state", int'(state), 0);
        repeat (5) @(negedge clk);
        #2 pll_locked = 1'b1;
        wait_done(200);

        // Soft reset in RUN: ASSERT for STRETCH cycles, one-cycle ack.
        @(negedge clk); #2 soft_rst_req = 1'b1;
        @(negedge clk);
        lit("soft_assert", int'(state), 3);
        lit("soft_out", int'(rstb_out), 0);
        repeat (STRETCH - 1) @(negedge clk);
        lit("soft_still_assert", int'(state), 3);
        lit("soft_no_ack_yet", int'(soft_rst_ack), 0);
        @(negedge clk);
        lit("soft_to_hold", int'(state), 0);
        lit("soft_ack", int'(soft_rst_ack), 1);
        @(negedge clk);
        lit("soft_ack_once", int'(soft_rst_ack), 0);
        wait_done(200);
        lit("held_req_no_retrig", int'(state), 2);
        #2 soft_rst_req = 1'b0;

        // Soft request coincident with lock loss: HOLD with immediate ack.
        @(negedge clk); #2 pll_locked = 1'b0;
        @(negedge clk);
        @(negedge clk); #2 soft_rst_req = 1'b1;
        @(negedge clk);
        lit("coinc_hold", int'(state), 0);
        lit("coinc_ack", int'(soft_rst_ack), 1);
        @(negedge clk);
        lit("coinc_ack_once", int'(soft_rst_ack), 0);
        lit("coinc_no_stretch", int'(state), 0);
        #2 soft_rst_req = 1'b0; pll_locked = 1'b1;
        wait_done(200);

        // Lock glitch shorter than the filter.
        do_reset();
        repeat (4) @(negedge clk);
        #2 pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        #2 pll_locked = 1'b0;
        repeat (40) @(negedge clk);
        lit("glitch_state", int'(state), 0);
        lit("glitch_out", int'(rstb_out), 0);

        // Asynchronous reset in the middle of RELEASE.
        #2 pll_locked = 1'b1;
        repeat (30) @(negedge clk);
        lit("mid_release_out", int'(rstb_out), 1);
        #2 rstb = 1'b0;
        #1;
        lit("async_abort_out", int'(rstb_out), 0);
        lit("async_abort_state", int'(state), 0);
        repeat (2) @(negedge clk);
        #2 rstb = 1'b1;
        wait_done(200);

`ifdef RST_SEQ_TIMEOUT_EN
        do_reset();
        for (int k = 1; k <= 55; k++) begin
            @(negedge clk);
            if (ecnt == 49) lit("timeout_at_49", int'(lock_timeout), 0);
            if (ecnt == 50) lit("timeout_at_50", int'(lock_timeout), 1);
        end
        #2 pll_locked = 1'b1;
        wait_done(200);
        lit("timeout_sticky", int'(lock_timeout), 1);
        do_reset();
        @(negedge clk);
        lit("timeout_cleared", int'(lock_timeout), 0);
`endif

        // Randomized traffic.
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk); #2;
            if ($urandom_range(0, 149) == 0) pll_locked = ~pll_locked;
            if ($urandom_range(0, 39) == 0) soft_rst_req = ~soft_rst_req;
            if ($urandom_range(0, 1999) == 0) begin
                rstb = 1'b0;
                repeat (2) @(negedge clk);
                #2 rstb = 1'b1;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Generates ordered, per-domain active-low resets from the board reset and a PLL lock indication.
- Holds all downstream domains in reset until lock is stable, then releases them one at a time with a fixed spacing.
- Re-asserts all resets on lock loss or on a software reset request, signalled with a req/ack handshake.
- Sits between the clock-management front end and the functional domains; each output feeds a per-domain synchronizer.

Parameters:
- NUM_OUT, 3, number of sequenced reset outputs; bit 0 is released first.
- STAGE_DLY, 16, clk cycles between successive releases; range 1..255.
- LOCK_FILT, 4, consecutive synced-high cycles of lock required before release starts; range 1..255.
- STRETCH, 8, clk cycles all outputs are held low for a soft reset; range 1..255.
- TIMEOUT_CYC, 1000, HOLD cycles before lock_timeout sets; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rstb  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock, asynchronous to clk; double-flop synchronised internally.
- soft_rst_req  in  1  software reset request; a rising edge is the request event.
- soft_rst_ack  out  1  one-cycle completion pulse for soft_rst_req.
- rstb_out  out  NUM_OUT  sequenced active-low resets.
- rst_done  out  1  high when all outputs are released (state RUN).
- state  out  2  current state: HOLD=0, RELEASE=1, RUN=2, ASSERT=3.
- lock_timeout  out  1  sticky timeout flag; present only with RST_SEQ_TIMEOUT_EN.

Behaviour:
- Reset: clk is the single clock; rstb is asynchronous, active-low.
  - rstb low forces rstb_out=0, rst_done=0, soft_rst_ack=0, state=HOLD.
  - All counters, synchroniser flops and the edge-detect register clear.
- Lock synchroniser: lock_s = pll_locked delayed by 2 edges.
- HOLD:
  - All rstb_out=0. filt_cnt increments while lock_s=1 and clears when lock_s=0.
  - Go to RELEASE on the edge where lock_s has been 1 for LOCK_FILT consecutive edges. If pll_locked rises before edge N, RELEASE is entered at edge N+2+LOCK_FILT.
  - A soft_rst_req rising edge seen in HOLD is not serviced; soft_rst_ack pulses on the next edge.
- RELEASE:
  - stage_cnt counts from 0. rstb_out[i] rises at entry + STAGE_DLY*(i+1) and stays high.
  - Go to RUN one edge after rstb_out[NUM_OUT-1] rises.
- RUN: rst_done=1; all outputs high.
- Lock loss: lock_s=0 in RELEASE or RUN drives all rstb_out=0 on the next edge and moves to HOLD. filt_cnt restarts from 0.
- Soft request:
  - A rising edge of soft_rst_req in RELEASE or RUN moves to ASSERT on the next edge, with all rstb_out=0.
  - ASSERT holds for STRETCH cycles, then moves to HOLD; soft_rst_ack pulses high for exactly that transition cycle.
- Priority: on the same edge, lock loss beats a soft request. The request is then treated as arriving in HOLD and is acked without a stretch.
- In ASSERT, lock_s is ignored because the outputs are already low. HOLD then re-qualifies lock.
- A soft_rst_req still held high after ack does not retrigger; only a new rising edge counts.
- rstb_out bits never glitch: each is a registered output, with no combinational path from inputs.
- rstb asserted mid-RELEASE or mid-ASSERT aborts immediately (asynchronously) to the reset values.

Optional Feature:
- RST_SEQ_TIMEOUT_EN defined:
  - Adds port lock_timeout and a HOLD dwell counter, cleared on leaving HOLD.
  - lock_timeout sets when the counter reaches TIMEOUT_CYC and stays set until rstb.
  - The flag does not alter sequencing.
- Not defined: port, counter and TIMEOUT_CYC logic are absent.

Test Plan:
- Power-up, defaults: pll_locked rises before edge 10 -> RELEASE at edge 16; rstb_out = 001 at 32, 011 at 48, 111 at 64; rst_done at 65.
- Lock glitch: pll_locked high for 3 cycles, then low -> state stays HOLD and rstb_out stays 000.
- Lock loss in RUN: pll_locked low -> rstb_out=000 within 3 edges of the fall, state=HOLD; full resequence after relock.
- Soft reset in RUN: req rising edge -> ASSERT next edge, outputs 000 for 8 cycles, ack pulse 1 cycle; resequence to rst_done.
- Soft req and lock loss on the same edge -> HOLD, not ASSERT; ack next edge; no extra stretch.
- With RST_SEQ_TIMEOUT_EN and TIMEOUT_CYC=50, lock never asserted -> lock_timeout=1 at edge 50; cleared only by rstb.
